// File: rtl/md_audio_mixer.sv
// Time-multiplexed stereo mixer: one channel per MCLK through a shared MAC, saturated signed output.
// Define MIX_LPF_EN to add a one-pole low-pass filter per side after saturation (adds one cycle of latency).
module md_audio_mixer #(
  parameter int CH        = 4,
  parameter int IN_W      = 16,
  parameter int GAIN_W    = 8,
  parameter int OUT_W     = 16,
  parameter int LPF_SHIFT = 2
) (
  input  logic                   MCLK,
  input  logic                   SRES,
  input  logic                   sample_stb,
  input  logic [CH*IN_W-1:0]     ch_data,
  input  logic [CH-1:0]          ch_offbin,
  input  logic [CH*GAIN_W-1:0]   gain_l,
  input  logic [CH*GAIN_W-1:0]   gain_r,
  output logic [OUT_W-1:0]       out_l,
  output logic [OUT_W-1:0]       out_r,
  output logic                   out_valid,
  output logic                   clip_l,
  output logic                   clip_r,
  output logic                   busy,
  output logic                   overrun
);

  localparam int IDX_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int ACC_W  = IN_W + GAIN_W + $clog2(CH) + 1;
  localparam int PROD_W = IN_W + GAIN_W + 2;
  localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (CH < 1 || OUT_W < IN_W || LPF_SHIFT < 0) begin : gBadCfg
    $error("md_audio_mixer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    OUT
`ifdef MIX_LPF_EN
    , FILT
`endif
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q;
  logic [CH*IN_W-1:0]       data_q;
  logic [CH-1:0]            offbin_q;
  logic [CH*GAIN_W-1:0]     gainL_q, gainR_q;
  logic signed [ACC_W-1:0]  accL_q, accR_q;
  logic [OUT_W-1:0]         outL_q, outR_q;
  logic                     clipL_q, clipR_q, overrun_q;

  logic [IN_W-1:0]          selData;
  logic                     selOffbin;
  logic [GAIN_W-1:0]        selGainL, selGainR;
  logic signed [IN_W:0]     sampleS;
  logic signed [PROD_W-1:0] prodL, prodR;
  logic signed [ACC_W-1:0]  accLNext, accRNext;
  logic [OUT_W:0]           satL, satR;
  logic                     lastCh;

  // Floor-shift back to unity scale, then clamp; MSB of the result flags clipping.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    logic signed [EXT_W-1:0] ext;
    sh  = acc >>> (GAIN_W - 1);
    ext = EXT_W'(sh);
    if (ext > SAT_MAX)      return {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (ext < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
    else                    return {1'b0, ext[OUT_W-1:0]};
  endfunction

  always_comb begin
    selData   = '0;
    selOffbin = 1'b0;
    selGainL  = '0;
    selGainR  = '0;
    for (int c = 0; c < CH; c++) begin
      if (idx_q == IDX_W'(c)) begin
        selData   = data_q[c*IN_W +: IN_W];
        selOffbin = offbin_q[c];
        selGainL  = gainL_q[c*GAIN_W +: GAIN_W];
        selGainR  = gainR_q[c*GAIN_W +: GAIN_W];
      end
    end
  end

  // Subtracting 2^(IN_W-1) from offset-binary is the same as inverting its MSB.
  assign sampleS  = selOffbin ? {~selData[IN_W-1], ~selData[IN_W-1], selData[IN_W-2:0]}
                              : {selData[IN_W-1], selData};
  assign prodL    = PROD_W'(sampleS) * PROD_W'($signed({1'b0, selGainL}));
  assign prodR    = PROD_W'(sampleS) * PROD_W'($signed({1'b0, selGainR}));
  assign accLNext = accL_q + ACC_W'(prodL);
  assign accRNext = accR_q + ACC_W'(prodR);
  assign satL     = saturate(accLNext);
  assign satR     = saturate(accRNext);
  assign lastCh   = (idx_q == IDX_W'(CH - 1));

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_stb) state_d = SUM;
      SUM:     if (lastCh) state_d = OUT;
`ifdef MIX_LPF_EN
      OUT:     state_d = FILT;
      FILT:    state_d = IDLE;
`else
      OUT:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef MIX_LPF_EN
  logic [OUT_W-1:0] satL_q, satR_q;
  logic             satClipL_q, satClipR_q;

  function automatic logic [OUT_W-1:0] lpfStep(input logic [OUT_W-1:0] y, input logic [OUT_W-1:0] x);
    logic signed [OUT_W:0] diff;
    diff = $signed({x[OUT_W-1], x}) - $signed({y[OUT_W-1], y});
    diff = diff >>> LPF_SHIFT;
    return y + diff[OUT_W-1:0];
  endfunction
`endif

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      idx_q     <= '0;
      data_q    <= '0;
      offbin_q  <= '0;
      gainL_q   <= '0;
      gainR_q   <= '0;
      accL_q    <= '0;
      accR_q    <= '0;
      outL_q    <= '0;
      outR_q    <= '0;
      clipL_q   <= 1'b0;
      clipR_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef MIX_LPF_EN
      satL_q     <= '0;
      satR_q     <= '0;
      satClipL_q <= 1'b0;
      satClipR_q <= 1'b0;
`endif
    end else begin
      overrun_q <= sample_stb && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (sample_stb) begin
            data_q   <= ch_data;
            offbin_q <= ch_offbin;
            gainL_q  <= gain_l;
            gainR_q  <= gain_r;
            accL_q   <= '0;
            accR_q   <= '0;
            idx_q    <= '0;
          end
        end
        SUM: begin
          accL_q <= accLNext;
          accR_q <= accRNext;
          idx_q  <= idx_q + 1'b1;
          // The final sum is saturated on the fly so results are registered on entry to OUT.
          if (lastCh) begin
`ifdef MIX_LPF_EN
            satL_q     <= satL[OUT_W-1:0];
            satR_q     <= satR[OUT_W-1:0];
            satClipL_q <= satL[OUT_W];
            satClipR_q <= satR[OUT_W];
`else
            outL_q  <= satL[OUT_W-1:0];
            outR_q  <= satR[OUT_W-1:0];
            clipL_q <= satL[OUT_W];
            clipR_q <= satR[OUT_W];
`endif
          end
        end
`ifdef MIX_LPF_EN
        OUT: begin
          outL_q  <= lpfStep(outL_q, satL_q);
          outR_q  <= lpfStep(outR_q, satR_q);
          clipL_q <= satClipL_q;
          clipR_q <= satClipR_q;
        end
`endif
        default: ;
      endcase
    end
  end

  assign out_l   = outL_q;
  assign out_r   = outR_q;
  assign clip_l  = clipL_q;
  assign clip_r  = clipR_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != IDLE);
`ifdef MIX_LPF_EN
  assign out_valid = (state_q == FILT);
`else
  assign out_valid = (state_q == OUT);
`endif

endmodule

// File: tb/tb_md_audio_mixer.sv
// Scoreboard bench for md_audio_mixer: directed mixes push expected results, a monitor checks each out_valid.
// Build with MIX_LPF_EN defined to exercise the low-pass filter sequence instead of the plain mix vectors.
module tb_md_audio_mixer;

  localparam int CH     = 4;
  localparam int IN_W   = 16;
  localparam int GAIN_W = 8;
  localparam int OUT_W  = 16;
`ifdef MIX_LPF_EN
  localparam int LAT = CH + 2;
`else
  localparam int LAT = CH + 1;
`endif

  logic                 MCLK = 1'b0;
  logic                 SRES = 1'b1;
  logic                 sampleStb = 1'b0;
  logic [CH*IN_W-1:0]   chData = '0;
  logic [CH-1:0]        chOffbin = '0;
  logic [CH*GAIN_W-1:0] gainL = '0;
  logic [CH*GAIN_W-1:0] gainR = '0;
  logic [OUT_W-1:0]     outL, outR;
  logic                 outValid, clipL, clipR, busy, overrun;

  md_audio_mixer #(
    .CH(CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W), .LPF_SHIFT(2)
  ) dut (
    .MCLK(MCLK), .SRES(SRES), .sample_stb(sampleStb),
    .ch_data(chData), .ch_offbin(chOffbin), .gain_l(gainL), .gain_r(gainR),
    .out_l(outL), .out_r(outR), .out_valid(outValid),
    .clip_l(clipL), .clip_r(clipR), .busy(busy), .overrun(overrun)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [15:0] expL;
    logic [15:0] expR;
    logic        expClipL;
    logic        expClipR;
    int          issueCycle;
  } expect_t;

  expect_t sbQueue[$];
  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int overrunCount = 0;
  logic prevValid = 1'b0;

  always @(posedge MCLK) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(negedge MCLK) begin : monitor
    expect_t e;
    if (overrun) overrunCount++;
    if (outValid) begin
      checkOutput("validPulse", 32'(prevValid), 32'd0);
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedValid: got out_valid=1 expected none, out_l=0x%0h", outL);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("outL", 32'(outL), 32'(e.expL));
        checkOutput("outR", 32'(outR), 32'(e.expR));
        checkOutput("clipL", 32'(clipL), 32'(e.expClipL));
        checkOutput("clipR", 32'(clipR), 32'(e.expClipR));
        checkOutput("latency", 32'(cycleCount - e.issueCycle), 32'(LAT));
      end
    end
    prevValid = outValid;
  end

  // Called at a falling edge; drives one strobe and optionally records the expected result.
  task automatic applyStimulus(input logic [63:0] data, input logic [3:0] offbin,
                               input logic [31:0] gl, input logic [31:0] gr,
                               input bit expectOut, input logic [15:0] eL, input logic [15:0] eR,
                               input logic eCL, input logic eCR);
    expect_t e;
    chData    = data;
    chOffbin  = offbin;
    gainL     = gl;
    gainR     = gr;
    sampleStb = 1'b1;
    if (expectOut) begin
      e.expL = eL;
      e.expR = eR;
      e.expClipL = eCL;
      e.expClipR = eCR;
      e.issueCycle = cycleCount;
      sbQueue.push_back(e);
    end
    @(negedge MCLK);
    sampleStb = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sbQueue.size() != 0 || busy) && n < 40) begin
      @(negedge MCLK);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL drainTimeout: got %0d pending expected 0", sbQueue.size());
    end
    @(negedge MCLK);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int ovBase;
    #2 SRES = 1'b0;
    repeat (3) @(negedge MCLK);
    checkOutput("rstOutL", 32'(outL), 32'd0);
    checkOutput("rstOutR", 32'(outR), 32'd0);
    checkOutput("rstValid", 32'(outValid), 32'd0);
    checkOutput("rstClipL", 32'(clipL), 32'd0);
    checkOutput("rstClipR", 32'(clipR), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstOverrun", 32'(overrun), 32'd0);
    SRES = 1'b1;
    repeat (8) @(negedge MCLK);
    checkOutput("idleValid", 32'(outValid), 32'd0);

    $display("[TB] unity / half gain");
`ifdef MIX_LPF_EN
    applyStimulus(64'h0000_0000_0000_1000, 4'b0000, 32'h0000_0080, 32'h0000_0040, 1'b1, 16'h0400, 16'h0200, 1'b0, 1'b0);
`else
    applyStimulus(64'h0000_0000_0000_1000, 4'b0000, 32'h0000_0080, 32'h0000_0040, 1'b1, 16'h1000, 16'h0800, 1'b0, 1'b0);
`endif
    checkOutput("busyDuringMix", 32'(busy), 32'd1);
    waitDrain();

    $display("[TB] reset mid-mix");
    applyStimulus(64'h0000_0000_0000_3000, 4'b0000, 32'h0000_0080, 32'h0000_0080, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge MCLK);
    SRES = 1'b0;
    #1;
    checkOutput("abortOutL", 32'(outL), 32'd0);
    checkOutput("abortOutR", 32'(outR), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortValid", 32'(outValid), 32'd0);
    repeat (2) @(negedge MCLK);
    SRES = 1'b1;
    repeat (10) @(negedge MCLK);

`ifdef MIX_LPF_EN
    $display("[TB] low-pass filter step response");
    applyStimulus(64'h0000_0000_0000_4000, 4'b0000, 32'h0000_0080, 32'h0000_0080, 1'b1, 16'h1000, 16'h1000, 1'b0, 1'b0);
    waitDrain();
    applyStimulus(64'h0000_0000_0000_4000, 4'b0000, 32'h0000_0080, 32'h0000_0080, 1'b1, 16'h1C00, 16'h1C00, 1'b0, 1'b0);
    waitDrain();
    applyStimulus(64'h0000_0000_0000_4000, 4'b0000, 32'h0000_0080, 32'h0000_0080, 1'b1, 16'h2500, 16'h2500, 1'b0, 1'b0);
    waitDrain();
`else
    $display("[TB] saturation");
    applyStimulus(64'h7000_7000_7000_7000, 4'b0000, 32'h8080_8080, 32'h8080_8080, 1'b1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(64'h9000_9000_9000_9000, 4'b0000, 32'h8080_8080, 32'h8080_8080, 1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(64'h0000_0000_0000_0100, 4'b0000, 32'h0000_0080, 32'h0000_0000, 1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] offset-binary and rounding");
    applyStimulus(64'h0000_0000_0000_0000, 4'b0010, 32'h0000_8000, 32'h0000_0000, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0);
    waitDrain();
    applyStimulus(64'h0000_0000_8000_0000, 4'b0010, 32'h0000_8000, 32'h0000_0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    waitDrain();
    applyStimulus(64'h0000_0000_0000_FFFF, 4'b0000, 32'h0000_0040, 32'h0000_0001, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    waitDrain();
    applyStimulus(64'h8100_0000_0000_0200, 4'b1000, 32'h8000_0080, 32'hC000_0040, 1'b1, 16'h0300, 16'h0280, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] overrun");
    ovBase = overrunCount;
    applyStimulus(64'h0000_0000_0000_2000, 4'b0000, 32'h0000_0080, 32'h0000_0080, 1'b1, 16'h2000, 16'h2000, 1'b0, 1'b0);
    @(negedge MCLK);
    applyStimulus(64'h0000_0000_0000_4000, 4'b0000, 32'h0000_0080, 32'h0000_0080, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(negedge MCLK);
    applyStimulus(64'h0000_0000_0000_3000, 4'b0000, 32'h0000_0080, 32'h0000_0080, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    waitDrain();
    repeat (6) @(negedge MCLK);
    checkOutput("overrunPulses", 32'(overrunCount - ovBase), 32'd2);
    checkOutput("holdOutL", 32'(outL), 32'h2000);
`endif

    checkOutput("queueEmpty", 32'(sbQueue.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
